serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: requests one subtraction; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: minuend, captured on the accepted start.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend, captured on the accepted start.
REQ-007 SHALL have port b_in, input, 1 bit: borrow-in, captured on the accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high while in SHIFT or DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse, high while in DONE.
REQ-010 SHALL have port diff, output, WIDTH bits: a - b - b_in, modulo 2^WIDTH.
REQ-011 SHALL have port b_out, output, 1 bit: final borrow; 1 when the unsigned a < b + b_in.
REQ-012 SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the result.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL, in IDLE with start=1 at an edge: load a, b and b_in into internal shift and borrow registers, clear the bit counter, and go to SHIFT.
REQ-015 SHALL, in each SHIFT cycle, process one bit LSB-first:
- d = a_i ^ b_i ^ borrow
- borrow' = (~a_i & b_i) | (~(a_i ^ b_i) & borrow)
- shift d into the result register from the MSB side.
REQ-016 SHALL spend exactly WIDTH cycles in SHIFT, then go to DONE.
REQ-017 SHALL, on the SHIFT-to-DONE edge, update diff, b_out and ovf together:
- diff = final result register
- b_out = final borrow
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
REQ-018 SHALL spend one cycle in DONE (done=1), then return to IDLE.
REQ-019 SHALL give a latency of WIDTH+1 edges from the edge that accepts start to the edge that raises done.
REQ-020 SHALL ignore start while busy=1; it is neither queued nor able to disturb the operation in flight.
REQ-021 SHALL hold diff, b_out and ovf stable from DONE until the next result update; a new start does not clear them.
REQ-022 SHALL accept a start asserted in the cycle immediately after DONE (back-to-back operation).
REQ-023 SHALL ignore changes on a, b and b_in after start is accepted.

Reset
REQ-024 SHALL, with rst=1 at a rising edge, force: state=IDLE, busy=0, done=0, diff=0, b_out=0, ovf=0, counter=0, internal registers=0.
REQ-025 SHALL give rst priority over start and over every state transition.
REQ-026 SHALL, on reset during SHIFT, discard the operation with no done pulse; start is accepted again from the first edge after rst deasserts.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE, SHIFT, DONE) and the default WIDTH constant in a shared package.
REQ-028 SHALL instantiate exactly one sub-module, full_subtractor: 1-bit combinational, ports x, y, b_in, d, b_out, used for every bit slice.
REQ-029 SHALL size the bit counter to ceil(log2(WIDTH+1)) bits.

Verification
REQ-030 Scenario 1: WIDTH=8, a=0x05, b=0x03, b_in=0 -> diff=0x02, b_out=0, ovf=0, done exactly 9 edges after start.
REQ-031 Scenario 2: a=0x03, b=0x05, b_in=0 -> diff=0xFE, b_out=1, ovf=0.
REQ-032 Scenario 3: a=0x80, b=0x01, b_in=0 -> diff=0x7F, b_out=0, ovf=1; then a=0x00, b=0x00, b_in=1 -> diff=0xFF, b_out=1, ovf=0.
REQ-033 Scenario 4: start held high continuously and operands changed mid-operation -> result matches the captured operands, one done per 10 cycles (9 busy cycles + 1 IDLE).
REQ-034 Scenario 5: rst=1 asserted on the 4th SHIFT cycle -> no done; all outputs 0 on the next cycle; a following start 0x10-0x01 -> diff=0x0F.
REQ-035 Scenario 6: random a, b, b_in over 1000 operations -> diff, b_out and ovf match a reference model.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : FSM state encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand width in bits
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit combinational full subtractor: x - y - b_in.
//   x, y  : operand bits
//   b_in  : incoming borrow
//   d     : difference bit
//   b_out : outgoing borrow
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b - b_in, one bit per clock, LSB first.
//   clk, rst     : clock and synchronous active-high reset
//   start        : request an operation (sampled only while idle)
//   a, b, b_in   : operands and borrow-in, captured when start is accepted
//   busy         : high while shifting or presenting the result
//   done         : one-cycle pulse when diff/b_out/ovf are updated
//   diff         : a - b - b_in modulo 2^WIDTH
//   b_out        : final borrow (unsigned a < b + b_in)
//   ovf          : two's-complement signed overflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   a_sh_reg;
  logic [WIDTH-1:0]   b_sh_reg;
  logic [WIDTH-1:0]   res_reg;
  logic               borrow_reg;
  logic               a_msb_reg;
  logic               b_msb_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic               bit_d;
  logic               bit_borrow;
  logic [WIDTH-1:0]   res_next;

  // The single bit slice always works on the current LSBs of the shifters.
  full_subtractor u_fs (
    .x     (a_sh_reg[0]),
    .y     (b_sh_reg[0]),
    .b_in  (borrow_reg),
    .d     (bit_d),
    .b_out (bit_borrow)
  );

  // Difference bits enter from the MSB side so that after WIDTH shifts
  // bit 0 has reached position 0.
  assign res_next = {bit_d, res_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      cnt_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      b_out      <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= b_in;
            // Sign bits are kept separately because the shifters lose them.
            a_msb_reg  <= a[WIDTH-1];
            b_msb_reg  <= b[WIDTH-1];
            res_reg    <= '0;
            cnt_reg    <= '0;
            busy       <= 1'b1;
            state_reg  <= SHIFT;
          end
        end

        SHIFT: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          borrow_reg <= bit_borrow;
          res_reg    <= res_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            // Publish using the values produced by this final bit.
            diff      <= res_next;
            b_out     <= bit_borrow;
            ovf       <= (a_msb_reg != b_msb_reg) && (res_next[WIDTH-1] != a_msb_reg);
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end

        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       b_in;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       b_out;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last_diff;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with the DUT idle. Counts edges with the
  // accepting edge as edge 1; done must first be seen after edge 9.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbi, input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    a = ta; b = tb; b_in = tbi; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb; b_in = ~tbi;  // must not affect the operation
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " early_done"}, 32'(done), 32'd0);
    chk({tag, " diff_held"}, 32'(diff), 32'(last_diff));
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 32'(lat), 32'd9);
    chk({tag, " diff"}, 32'(diff), 32'(ed));
    chk({tag, " b_out"}, 32'(b_out), 32'(eb));
    chk({tag, " ovf"}, 32'(ovf), 32'(eo));
    $display("op %s: a=%02h b=%02h b_in=%0d -> diff=%02h b_out=%0d ovf=%0d lat=%0d",
             tag, ta, tb, tbi, diff, b_out, ovf, lat);
    last_diff = ed;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " idle"}, 32'(busy), 32'd0);
    chk({tag, " diff_stable"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    logic [7:0] ra, rb, op2a, op2b;
    logic       rbi;
    logic [8:0] r;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    last_diff = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", 32'(diff), 32'd0);
    chk("reset b_out", 32'(b_out), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // Scenarios 1-3 (back-to-back: each start is given in the idle cycle).
    do_op("s1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    do_op("s2", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    do_op("s3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    do_op("s3b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_op("s3c", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Scenario 4: start held high, operands scrambled mid-operation.
    // Op1 0x40-0x25-1 = 0x1A; op2 (set in the idle cycle) 0x10-0x20-0 = 0xF0.
    op2a = 8'h10; op2b = 8'h20;
    a = 8'h40; b = 8'h25; b_in = 1'b1; start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("s4 done@%0d", n), 32'(done), 32'((n == 9) || (n == 19)));
      if (n == 9) begin
        chk("s4 op1 diff", 32'(diff), 32'h1A);
        chk("s4 op1 b_out", 32'(b_out), 32'd0);
        chk("s4 op1 ovf", 32'(ovf), 32'd0);
        $display("op s4a: diff=%02h b_out=%0d ovf=%0d", diff, b_out, ovf);
      end
      if (n == 19) begin
        chk("s4 op2 diff", 32'(diff), 32'hF0);
        chk("s4 op2 b_out", 32'(b_out), 32'd1);
        chk("s4 op2 ovf", 32'(ovf), 32'd0);
        $display("op s4b: diff=%02h b_out=%0d ovf=%0d", diff, b_out, ovf);
      end
      if (n == 10) begin
        a = op2a; b = op2b; b_in = 1'b0;
      end else begin
        a = 8'($urandom); b = 8'($urandom); b_in = 1'($urandom);
      end
      if (n == 20) start = 1'b0;
    end
    last_diff = 8'hF0;

    // Scenario 5: reset during the 4th SHIFT cycle.
    a = 8'h37; b = 8'h11; b_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("s5 busy", 32'(busy), 32'd0);
    chk("s5 done", 32'(done), 32'd0);
    chk("s5 diff", 32'(diff), 32'd0);
    chk("s5 b_out", 32'(b_out), 32'd0);
    chk("s5 ovf", 32'(ovf), 32'd0);
    $display("op s5 reset: busy=%0d diff=%02h", busy, diff);
    rst = 1'b0;
    last_diff = 8'h00;
    do_op("s5", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    // Scenario 6: random operands against a 9-bit arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      r   = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
      do_op($sformatf("r%0d", i), ra, rb, rbi, r[7:0], r[8],
            (ra[7] != rb[7]) && (r[7] != ra[7]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
